// File: rtl/snake_controller.sv
// snake_controller: sequences snake moves, collision checks, growth and scoring on each movement tick.
module snake_controller #(
    parameter int FIELD_W  = 18,
    parameter int FIELD_H  = 6,
    parameter int MAX_LEN  = 10,
    parameter int INIT_LEN = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        tick,
    input  logic [3:0]  dir_btn,
    input  logic [5:0]  apple_x,
    input  logic [4:0]  apple_y,
    output logic [10:0] snake0,
    output logic [10:0] snake1,
    output logic [10:0] snake2,
    output logic [10:0] snake3,
    output logic [10:0] snake4,
    output logic [10:0] snake5,
    output logic [10:0] snake6,
    output logic [10:0] snake7,
    output logic [10:0] snake8,
    output logic [10:0] snake9,
    output logic [3:0]  length,
    output logic [7:0]  score,
    output logic        apple_eaten,
    output logic        game_over
);
    typedef enum logic [2:0] {IDLE, RUN, CHECK, SHIFT, DEAD} state_t;
    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
    localparam logic [5:0] FW = 6'(FIELD_W);
    localparam logic [4:0] FH = 5'(FIELD_H);
    localparam logic [3:0] ML = 4'(MAX_LEN);
    state_t state_q, state_d;
    dir_t dir, pend_dir, btn_dir, ref_dir;
    logic [10:0] seg [MAX_LEN];
    logic [10:0] init_seg [MAX_LEN];
    logic [10:0] nh;
    logic [5:0] nx;
    logic [4:0] ny;
    logic eat, eat_q, wall, hit, restart, active;
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++)
            init_seg[i] = i < INIT_LEN ? {5'd3, 6'(INIT_LEN + 1 - i)} : 11'h7FF;
    end
    assign btn_dir = dir_btn[3] ? UP : dir_btn[2] ? DOWN : dir_btn[1] ? LEFT : RIGHT;
    // a press coincident with a tick is checked against the direction that tick commits
    assign ref_dir = (state_q == RUN && tick) ? pend_dir : dir;
    assign active  = state_q == RUN || state_q == CHECK || state_q == SHIFT;
    assign restart = start && (state_q == IDLE || state_q == DEAD);
    assign nx = pend_dir == LEFT ? seg[0][5:0] - 6'd1 : pend_dir == RIGHT ? seg[0][5:0] + 6'd1 : seg[0][5:0];
    assign ny = pend_dir == UP ? seg[0][10:6] - 5'd1 : pend_dir == DOWN ? seg[0][10:6] + 5'd1 : seg[0][10:6];
    assign wall = nh[5:0] >= FW || nh[10:6] >= FH;
    assign eat  = nh == {apple_y, apple_x};
    // the tail only counts as an obstacle when it will not vacate (growing move)
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (seg[i] == nh && (i + 1 < int'(length) || (eat && i < int'(length))))
                hit = 1'b1;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = tick ? CHECK : RUN;
            CHECK:   state_d = (wall || hit) ? DEAD : SHIFT;
            SHIFT:   state_d = RUN;
            DEAD:    state_d = start ? RUN : DEAD;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg         <= init_seg;
            dir         <= RIGHT;
            pend_dir    <= RIGHT;
            length      <= 4'(INIT_LEN);
            score       <= 8'd0;
            apple_eaten <= 1'b0;
            game_over   <= 1'b0;
            nh          <= 11'h7FF;
            eat_q       <= 1'b0;
        end else begin
            apple_eaten <= 1'b0;
            if (restart) begin
                seg       <= init_seg;
                dir       <= RIGHT;
                pend_dir  <= RIGHT;
                length    <= 4'(INIT_LEN);
                score     <= 8'd0;
                game_over <= 1'b0;
            end else begin
                if (active && |dir_btn && btn_dir != dir_t'(ref_dir ^ 2'b01))
                    pend_dir <= btn_dir;
                if (state_q == RUN && tick) begin
                    dir <= pend_dir;
                    nh  <= {ny, nx};
                end
                if (state_q == CHECK) begin
                    eat_q     <= eat;
                    game_over <= wall || hit;
                end
                if (state_q == SHIFT) begin
                    seg[0] <= nh;
                    for (int i = 1; i < MAX_LEN; i++)
                        seg[i] <= seg[i-1];
                    if (eat_q) begin
                        apple_eaten <= 1'b1;
                        score       <= score + {7'd0, score != 8'hFF};
                        length      <= length + {3'd0, length < ML};
                    end else if (length < ML) begin
                        seg[length] <= 11'h7FF;
                    end
                end
            end
        end
    end
    assign snake0 = seg[0];
    assign snake1 = seg[1];
    assign snake2 = seg[2];
    assign snake3 = seg[3];
    assign snake4 = seg[4];
    assign snake5 = seg[5];
    assign snake6 = seg[6];
    assign snake7 = seg[7];
    assign snake8 = seg[8];
    assign snake9 = seg[9];
endmodule

// File: doc/snake_controller.md
# snake_controller

Game-sequencing controller for the snake datapath. It owns the snake body registers and direction state. On each movement tick it computes the next head cell, checks walls, self-collision and apple capture, then shifts the body and grows it. It drives the packed segment buses consumed by the VGA renderer and reads back the renderer's current apple position.

## Interface
- FIELD_W, 18, playable columns; x in 0..FIELD_W-1, wall column at x = FIELD_W
- FIELD_H, 6, playable rows; y in 0..FIELD_H-1, wall row at y = FIELD_H
- MAX_LEN, 10, segment count; fixed by the renderer's 10 segment ports
- INIT_LEN, 3, length after reset or restart
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset; low = reset
- start  input  1  one-cycle pulse; starts the game from IDLE, or restarts it from DEAD
- tick  input  1  one-cycle movement strobe from the game-speed divider
- dir_btn  input  4  one-cycle direction pulses: [3] up, [2] down, [1] left, [0] right
- apple_x  input  6  current apple column, from the renderer's CurAppleX
- apple_y  input  5  current apple row, from the renderer's CurAppleY
- snake0..snake9  output  11 each  segment i packed as {y[4:0], x[5:0]}; snake0 is the head
- length  output  4  active segment count, INIT_LEN..MAX_LEN
- score  output  8  apples eaten; saturates at 255
- apple_eaten  output  1  one-cycle pulse when the head lands on the apple
- game_over  output  1  high while in DEAD

## Operation
- **States:** IDLE, RUN, CHECK, SHIFT, DEAD.
- **Reset** (reset low, asynchronous):
  - state = IDLE; dir = RIGHT; pend_dir = RIGHT; length = 3; score = 0; apple_eaten = 0; game_over = 0.
  - snake0 = (4,3), snake1 = (3,3), snake2 = (2,3); snake3..9 = 11'h7FF (x=63, y=31, off-field).
- **IDLE:** tick and dir_btn are ignored. start → re-initialise to the reset image (except state) → RUN.
- **Direction latch** (RUN, CHECK, SHIFT):
  - A dir_btn pulse is resolved by priority up > down > left > right.
  - The result is written to pend_dir unless it is the exact reverse of the committed dir; a reversal request is dropped.
  - A later press before the next tick overwrites pend_dir.
- **RUN:** on tick:
  - dir ← pend_dir.
  - next_head ← snake0 offset one cell in pend_dir (up = y-1, down = y+1, left = x-1, right = x+1).
  - Offset arithmetic is unsigned modulo field width, so x=0 moving left gives 63 and y=0 moving up gives 31.
  - → CHECK.
- **CHECK:**
  - wall = next_head.x ≥ FIELD_W or next_head.y ≥ FIELD_H.
  - eat = next_head equals (apple_x, apple_y).
  - self = next_head equals any segment i with i < length-1; if eat, the check extends to i < length (the tail does not vacate).
  - Segments i ≥ length are never compared.
  - wall or self → DEAD, game_over ← 1. Otherwise → SHIFT.
- **SHIFT:**
  - snake[i] ← snake[i-1] for i = 1..MAX_LEN-1; snake0 ← next_head.
  - If eat: apple_eaten pulses; score increments (saturating); length increments if below MAX_LEN. At MAX_LEN the length holds, and the last segment shifted out is dropped.
  - If not eat: segment index `length` is forced back to 11'h7FF, so inactive segments stay off-field.
  - → RUN.
- **DEAD:**
  - Snake registers are frozen; tick and dir_btn are ignored.
  - start → reset image, game_over ← 0 → RUN.
- **Apple:** the renderer relocates the apple when the head matches it. The controller does not drive apple position.

## Timing
- Tick sampled at edge k (RUN): state is CHECK after k. After k+1 the state is SHIFT, or DEAD with game_over already high. After k+2 snake0..9, length, score and apple_eaten are updated, and the state is back in RUN.
- Update latency is 2 cycles from tick to the new head on the outputs.
- A tick arriving in CHECK or SHIFT is ignored. The tick period must be ≥ 3 cycles.
- start coincident with tick in IDLE or DEAD: start wins, and that tick is ignored.
- dir_btn coincident with tick: the tick uses the pend_dir value from before the press. The press updates pend_dir for the next tick, with the reversal check made against the newly committed dir.
- reset asserted mid-move (any state): immediate return to the reset image; no partial shift is visible after release.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** pulse reset low → snake0=11'h0C4, snake1=11'h0C3, snake2=11'h0C2, snake3..9=11'h7FF, length=3, game_over=0. Ticks before start leave the outputs unchanged.
- **Movement:** start, then 3 ticks with no buttons → snake0 = (7,3), snake2 = (5,3). Each update appears 2 cycles after its tick.
- **Reversal:** in RUN with dir RIGHT, press left then tick → head moves right. Press up then tick → head moves to y=2.
- **Apple:** set apple = (5,3), start, tick → apple_eaten pulses once, length=4, score=1, snake3 = (2,3). Feed apples repeatedly → length saturates at 10, score keeps counting.
- **Wall:** head at (17,3) moving right, tick → game_over=1 two cycles later, snake frozen. Head at (0,y) moving left, tick → DEAD. start → reset image and RUN.
- **Self-collision:** length 5, then press down, left, up across successive ticks → head meets its body, DEAD. Pulse reset low during CHECK → IDLE with the reset image.
